systolic_sequencer: RTL and testbench

- Controller that sequences one matrix-multiply pass through the input skewer and systolic array.
- Accepts a start handshake, then walks four phases:
  - FEED: streams MATRIX_SIZE input vectors into the skewer.
  - DRAIN: zero-fills so every skewed row plus the array wavefront flushes through.
  - CAPTURE: strobes result rows out of the array.
  - DONE: pulses completion.
- Sits between the operand buffers / host control and the input skewer's enable plus the array's result-capture logic.

---
 rtl/systolic_sequencer.sv | 148 ++++++++++++++
 tb/tb_systolic_sequencer.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/systolic_sequencer.sv
`timescale 1ns/1ps
// Pass controller for the input skewer and systolic array:
// FEED operands, DRAIN the skewed wavefront, CAPTURE result rows, pulse DONE.
module systolic_sequencer #(
    parameter int MATRIX_SIZE = 2,
    parameter int DATA_SIZE   = 32,
    parameter int SKEW_STRIDE = 4,
    parameter int CNT_W       = 16,
    localparam int IDX_W      = (MATRIX_SIZE > 1) ? $clog2(MATRIX_SIZE) : 1
) (
    input  logic                           clk,
    input  logic                           reset_n,
    input  logic                           start_valid,
    output logic                           start_ready,
    input  logic                           pause,
    input  logic                           abort,
    input  logic [DATA_SIZE*MATRIX_SIZE-1:0] data_in,
    output logic [IDX_W-1:0]               feed_idx,
    output logic [DATA_SIZE*MATRIX_SIZE-1:0] data_out,
    output logic                           skew_enable,
    output logic                           capture_en,
    output logic [IDX_W-1:0]               capture_idx,
    output logic                           busy,
    output logic                           done,
    output logic [CNT_W-1:0]               cycle_count
);

    localparam int DRAIN_CYCLES =
        SKEW_STRIDE*(MATRIX_SIZE-1) + MATRIX_SIZE + 2*MATRIX_SIZE - 1;
    localparam logic [CNT_W-1:0] FEED_LAST  = CNT_W'(MATRIX_SIZE-1);
    localparam logic [CNT_W-1:0] DRAIN_LAST = CNT_W'(DRAIN_CYCLES-1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FEED,
        S_DRAIN,
        S_CAPTURE,
        S_DONE
    } state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] cyc_q, cyc_d;
    logic             rdy_q, busy_q, skew_q, cap_q, done_q;
    logic [IDX_W-1:0] fidx_q, cidx_q;
    logic             run;

    // DONE always completes, so it counts even while paused
    assign run = (state_q == S_DONE) || !pause;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        cyc_d   = cyc_q;
        if (state_q != S_IDLE && run && cyc_q != '1) begin
            cyc_d = cyc_q + 1'b1;
        end
        unique case (state_q)
            S_IDLE: begin
                if (start_valid && !abort) begin
                    state_d = S_FEED;
                    cnt_d   = '0;
                    cyc_d   = '0;
                end
            end
            S_FEED: begin
                if (!pause) begin
                    if (cnt_q == FEED_LAST) begin
                        state_d = S_DRAIN;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            S_DRAIN: begin
                if (!pause) begin
                    if (cnt_q == DRAIN_LAST) begin
                        state_d = S_CAPTURE;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            S_CAPTURE: begin
                if (!pause) begin
                    if (cnt_q == FEED_LAST) begin
                        state_d = S_DONE;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase
        if (abort && state_q != S_IDLE) begin
            state_d = S_IDLE;
            cnt_d   = '0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            cyc_q   <= '0;
            rdy_q   <= 1'b1;
            busy_q  <= 1'b0;
            skew_q  <= 1'b0;
            cap_q   <= 1'b0;
            done_q  <= 1'b0;
            fidx_q  <= '0;
            cidx_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            cyc_q   <= cyc_d;
            rdy_q   <= (state_d == S_IDLE);
            busy_q  <= (state_d != S_IDLE);
            skew_q  <= (state_d == S_FEED) || (state_d == S_DRAIN);
            cap_q   <= (state_d == S_CAPTURE);
            done_q  <= (state_d == S_DONE);
            fidx_q  <= (state_d == S_FEED) ? cnt_d[IDX_W-1:0] : '0;
            cidx_q  <= (state_d == S_CAPTURE) ? cnt_d[IDX_W-1:0] : '0;
        end
    end

    // pause gates the strobes in the same cycle so no shift/capture is repeated
    assign skew_enable = skew_q & ~pause;
    assign capture_en  = cap_q & ~pause;
    assign start_ready = rdy_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign feed_idx    = fidx_q;
    assign capture_idx = cidx_q;
    assign cycle_count = cyc_q;
    assign data_out    = (state_q == S_FEED) ? data_in : '0;

endmodule

// File: tb/tb_systolic_sequencer.sv
`timescale 1ns/1ps
// Bench for systolic_sequencer: position-based pass model checked every
// cycle, plus directed scenarios with literal expectations.
module tb_systolic_sequencer;

    localparam int M    = 2;
    localparam int DS   = 32;
    localparam int SS   = 4;
    localparam int CW   = 16;
    localparam int D    = SS*(M-1) + 3*M - 1;
    localparam int PASS = 2*M + D + 1;
    localparam int M2   = 4;

    logic clk = 1'b0;
    logic reset_n = 1'b1;
    logic start_valid = 1'b0;
    logic pause = 1'b0;
    logic abort = 1'b0;
    logic [DS*M-1:0] data_in = 64'h1234_5678_9abc_def0;
    logic start_ready, skew_enable, capture_en, busy, done;
    logic [0:0] feed_idx, capture_idx;
    logic [DS*M-1:0] data_out;
    logic [CW-1:0] cycle_count;

    logic start2 = 1'b0;
    logic pause2 = 1'b0;
    logic abort2 = 1'b0;
    logic [DS*M2-1:0] data_in2 = {32'h1, 32'h2, 32'h3, 32'h4};
    logic start_ready2, skew_enable2, capture_en2, busy2, done2;
    logic [1:0] feed_idx2, capture_idx2;
    logic [DS*M2-1:0] data_out2;
    logic [CW-1:0] cycle_count2;

    systolic_sequencer #(.MATRIX_SIZE(M), .DATA_SIZE(DS),
                         .SKEW_STRIDE(SS), .CNT_W(CW)) dut (
        .clk(clk), .reset_n(reset_n),
        .start_valid(start_valid), .start_ready(start_ready),
        .pause(pause), .abort(abort),
        .data_in(data_in), .feed_idx(feed_idx), .data_out(data_out),
        .skew_enable(skew_enable), .capture_en(capture_en),
        .capture_idx(capture_idx), .busy(busy), .done(done),
        .cycle_count(cycle_count)
    );

    systolic_sequencer #(.MATRIX_SIZE(M2), .DATA_SIZE(DS),
                         .SKEW_STRIDE(4), .CNT_W(CW)) dut2 (
        .clk(clk), .reset_n(reset_n),
        .start_valid(start2), .start_ready(start_ready2),
        .pause(pause2), .abort(abort2),
        .data_in(data_in2), .feed_idx(feed_idx2), .data_out(data_out2),
        .skew_enable(skew_enable2), .capture_en(capture_en2),
        .capture_idx(capture_idx2), .busy(busy2), .done(done2),
        .cycle_count(cycle_count2)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_pass = 0;

    task automatic chk(input string nm, input logic [127:0] act,
                       input logic [127:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    // Model: a pass is a position 0..PASS-1 that advances on unpaused cycles
    bit m_act = 1'b0;
    int m_pos = 0;
    int m_cyc = 0;

    always @(negedge clk) begin
        logic e_skew, e_cap, e_done;
        logic [DS*M-1:0] e_data;
        if (!reset_n) begin
            m_act = 1'b0;
            m_pos = 0;
            m_cyc = 0;
            chk("rst_busy", busy, 0);
            chk("rst_ready", start_ready, 1);
            chk("rst_skew", skew_enable, 0);
            chk("rst_cap", capture_en, 0);
            chk("rst_done", done, 0);
            chk("rst_cyc", cycle_count, 0);
        end else begin
            e_skew = 1'b0;
            e_cap  = 1'b0;
            e_done = 1'b0;
            e_data = '0;
            if (m_act) begin
                if (m_pos < M) begin
                    e_skew = !pause;
                    e_data = data_in;
                    chk("m_feed_idx", feed_idx, m_pos);
                end else if (m_pos < M + D) begin
                    e_skew = !pause;
                end else if (m_pos < 2*M + D) begin
                    e_cap = !pause;
                    chk("m_cap_idx", capture_idx, m_pos - M - D);
                end else begin
                    e_done = 1'b1;
                end
            end
            chk("m_busy", busy, m_act);
            chk("m_ready", start_ready, !m_act);
            chk("m_skew", skew_enable, e_skew);
            chk("m_cap", capture_en, e_cap);
            chk("m_done", done, e_done);
            chk("m_data", data_out, e_data);
            chk("m_cyc", cycle_count, m_cyc);
            if (!m_act) begin
                if (start_valid && !abort) begin
                    m_act = 1'b1;
                    m_pos = 0;
                    m_cyc = 0;
                end
            end else begin
                if ((m_pos == PASS-1 || !pause) && m_cyc < (1 << CW) - 1)
                    m_cyc++;
                if (abort || m_pos == PASS-1) m_act = 1'b0;
                else if (!pause) m_pos++;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic launch();
        start_valid = 1'b1;
        tick();
        start_valid = 1'b0;
    endtask

    initial begin
        int w;
        #1 reset_n = 1'b0;
        repeat (2) @(negedge clk);
        #2 reset_n = 1'b1;
        tick();
        tick();

        // Basic pass; we are in cycle 1 after launch
        launch();
        chk("s1_feed0_idx", feed_idx, 0);
        chk("s1_feed0_skew", skew_enable, 1);
        chk("s1_feed0_data", data_out, 64'h1234_5678_9abc_def0);
        tick();
        chk("s1_feed1_idx", feed_idx, 1);
        tick();
        chk("s1_drain_data", data_out, 0);
        chk("s1_drain_skew", skew_enable, 1);
        repeat (9) tick();
        chk("s1_cap0_en", capture_en, 1);
        chk("s1_cap0_idx", capture_idx, 0);
        chk("s1_cap0_skew", skew_enable, 0);
        tick();
        chk("s1_cap1_idx", capture_idx, 1);
        tick();
        chk("s1_done14", done, 1);
        tick();
        chk("s1_done_off", done, 0);
        chk("s1_ready15", start_ready, 1);
        chk("s1_cyc14", cycle_count, 14);

        // Pause for 3 cycles at DRAIN cnt 4 (cycle 7)
        launch();
        repeat (6) tick();
        pause = 1'b1;
        #1 chk("s2_p0_skew", skew_enable, 0);
        tick();
        chk("s2_p1_skew", skew_enable, 0);
        tick();
        chk("s2_p2_skew", skew_enable, 0);
        tick();
        pause = 1'b0;
        #1 chk("s2_resume_skew", skew_enable, 1);
        repeat (6) tick();
        chk("s2_pre_done16", done, 0);
        tick();
        chk("s2_done17", done, 1);
        tick();
        chk("s2_cyc14", cycle_count, 14);

        // Abort in CAPTURE cnt 0, then immediate relaunch
        launch();
        repeat (11) tick();
        chk("s3_cap0", capture_en, 1);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("s3_busy", busy, 0);
        chk("s3_ready", start_ready, 1);
        chk("s3_nodone", done, 0);
        launch();
        chk("s3_relaunch", busy, 1);
        chk("s3_relaunch_idx", feed_idx, 0);
        repeat (13) tick();
        chk("s3_done", done, 1);
        tick();

        // abort with start_valid in IDLE: no launch
        abort = 1'b1;
        start_valid = 1'b1;
        tick();
        abort = 1'b0;
        start_valid = 1'b0;
        chk("s3_idle_abort", busy, 0);

        // Asynchronous reset mid-FEED
        launch();
        tick();
        #2 reset_n = 1'b0;
        #1;
        chk("s4_busy", busy, 0);
        chk("s4_skew", skew_enable, 0);
        chk("s4_ready", start_ready, 1);
        chk("s4_cyc", cycle_count, 0);
        chk("s4_fidx", feed_idx, 0);
        @(negedge clk);
        #2 reset_n = 1'b1;
        tick();
        chk("s4_idle", busy, 0);

        // Back-to-back passes with start_valid held
        start_valid = 1'b1;
        tick();
        for (int p = 0; p < 3; p++) begin
            w = 1;
            while (!done && w < 40) begin
                tick();
                w++;
            end
            chk("s5_done_at", w, 14);
            tick();
            chk("s5_gap_ready", start_ready, 1);
            chk("s5_gap_cyc", cycle_count, 14);
            start_valid = (p != 2);
            tick();
            chk("s5_next_busy", busy, p != 2);
        end
        start_valid = 1'b0;
        tick();

        // MATRIX_SIZE = 4 instance
        start2 = 1'b1;
        tick();
        start2 = 1'b0;
        chk("s6_data", data_out2, {32'h1, 32'h2, 32'h3, 32'h4});
        for (int i = 0; i < 4; i++) begin
            chk("s6_fidx", feed_idx2, i);
            tick();
        end
        w = 5;
        while (!done2 && w < 60) begin
            tick();
            w++;
        end
        chk("s6_done_at", w, 32);
        tick();
        chk("s6_cyc", cycle_count2, 32);
        chk("s6_ready", start_ready2, 1);

        tick();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
